health_ctrl: RTL and testbench
==============================

// Module: health_ctrl
// PURPOSE
//   Player health manager that sits directly downstream of ghosts_logic. It consumes the
//   per-ghost hit levels (got_hit1..4) and the 60 Hz game tick.
//   - Edge-detects hits; applies 1 HP damage per collision event.
//   - Enforces a post-hit invulnerability window.
//   - Drives the HP digit to multidigit and the sticky game_over / blink flags to drawcon.
// PARAMETERS
//   START_HP      3    HP loaded on reset/restart (1..MAX_HP)
//   MAX_HP        9    heal saturation ceiling; must fit one BCD digit
//   INVULN_TICKS  90   game ticks of invulnerability after damage (1.5 s @ 60 Hz)
//   BLINK_TICKS   8    ticks per blink half-period while invulnerable
// PORTS
//   clk        in   1  system clock; single clock domain
//   rst        in   1  asynchronous, active-low reset
//   tick       in   1  1-clk enable pulse at 60 Hz; all timers advance only on tick
//   got_hit    in   4  per-ghost collision levels from ghosts_logic (bit0 = ghost1)
//   heal       in   1  1-clk pulse: +1 HP (egg bonus)
//   restart    in   1  1-clk pulse: reload START_HP, clear game_over
//   hp_dig     out  4  current HP, BCD 0..9, to multidigit dig4
//   game_over  out  1  sticky; high in DEAD
//   invuln     out  1  high in INVULN
//   blink      out  1  sprite-hide request for drawcon; toggles during INVULN, else 0
//   hit_ack    out  1  1-clk pulse on each applied damage (LED/sound hook)
// BEHAVIOUR
//   Reset (rst=0, async): state=ALIVE, hp_dig=START_HP, game_over=0, invuln=0, blink=0,
//     hit_ack=0, timers=0, edge-detect history=4'b1111 (lines high at release give no hit).
//   Hit event:
//     new_hit = |(got_hit & ~got_hit_q), evaluated every clk. History updates every clk.
//     Multiple bits rising in the same clk = ONE event, 1 HP.
//   States:
//     ALIVE:  new_hit & hp_dig>1  -> hp-1, hit_ack=1, load inv_cnt=INVULN_TICKS,
//               blink_cnt=BLINK_TICKS, -> INVULN.
//             new_hit & hp_dig==1 -> hp=0, hit_ack=1, -> DEAD.
//     INVULN: new_hit ignored (no damage, no hit_ack).
//             On tick: inv_cnt-1 and blink_cnt-1; blink_cnt reaching 0 toggles blink and
//               reloads BLINK_TICKS.
//             inv_cnt reaching 0 on a tick -> ALIVE with blink=0.
//     DEAD:   hp_dig=0, game_over=1; new_hit and heal ignored.
//   Latency: hp_dig / state / hit_ack change on the clk edge after the got_hit rising
//     sample, i.e. 2 clk from the got_hit edge at the input.
//   heal: in ALIVE/INVULN, hp = min(hp+1, MAX_HP). Does not alter timers or state.
//     If heal and new_hit occur in the same clk in ALIVE, net hp change = 0, hit_ack=1, and
//     INVULN is entered. The hp==1 death check uses the net value: no death, since net hp = 1.
//   restart: honoured in every state; highest priority over hit/heal that clk.
//     Result equals reset values, except the edge history keeps sampling.
//   Width rules: hp held as 4-bit unsigned. Never decrements below 0; never exceeds MAX_HP.
//     inv_cnt width = $clog2(INVULN_TICKS+1).
//   tick and a hit in the same clk: the hit is applied first. The freshly loaded counter is
//     not decremented in that clk.
// STRUCTURE
//   Shared package game_pkg:
//     - hp_t (4-bit) typedef.
//     - health_state_t enum {ALIVE, INVULN, DEAD}.
//     - TICK_HZ=60 constant.
//   Sub-module rise_detect (WIDTH param):
//     - Per-bit registered rising-edge detector with configurable reset history.
//     - Reused for button edges in game_logic.
//   Remainder is one registered 3-state FSM plus the inv_cnt and blink_cnt counters.
// TESTING
//   1. Release rst with got_hit=4'b0001 held -> no hit_ack; hp_dig=3.
//      Drop the line, raise it again -> hp_dig=2, hit_ack for exactly 1 clk, invuln=1.
//   2. Raise bits 0 and 2 in the same clk -> hp 3->2, a single hit_ack.
//      Further hits within 90 ticks -> hp stays 2.
//      invuln falls after exactly 90 ticks; blink toggles every 8 ticks meanwhile.
//   3. Three spaced hits from START_HP=3 -> hp 2,1,0; game_over=1 on the third.
//      Then heal and hits -> no change. restart -> hp=3, game_over=0, ALIVE.
//   4. 7 heals from hp=3 -> hp saturates at 9.
//      At hp=1, heal and a new hit in the same clk -> hp=1, INVULN, no game_over.
//   5. Assert rst mid-INVULN (inv_cnt=40) -> outputs at reset values immediately
//      (async, no clk edge needed).
//   6. Hit coincident with tick -> inv_cnt reads INVULN_TICKS next clk, not INVULN_TICKS-1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-wide types and constants used by the gameplay control blocks.
package game_pkg;

  typedef logic [3:0] hp_t;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } health_state_t;

  localparam int TICK_HZ = 60;

endpackage

// File: rtl/rise_detect.sv
// Per-bit registered rising-edge detector; history resets to RESET_VAL so lines
// already high when reset releases do not produce an edge.
module rise_detect #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist_p0;

  // stage p0 -> p1: compare the new sample against the previous one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_p0 <= RESET_VAL;
      rise    <= '0;
    end else begin
      hist_p0 <= din;
      rise    <= din & ~hist_p0;
    end
  end

endmodule

// File: rtl/health_ctrl.sv
// Player health manager: 1 HP per ghost collision event, timed invulnerability with
// blink, heal saturation, sticky game over and restart.
module health_ctrl
  import game_pkg::*;
#(
  parameter int START_HP     = 3,
  parameter int MAX_HP       = 9,
  parameter int INVULN_TICKS = 90,
  parameter int BLINK_TICKS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] got_hit,
  input  logic       heal,
  input  logic       restart,
  output logic [3:0] hp_dig,
  output logic       game_over,
  output logic       invuln,
  output logic       blink,
  output logic       hit_ack
);

  localparam int IW = $clog2(INVULN_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam hp_t           START_V  = hp_t'(START_HP);
  localparam hp_t           MAX_V    = hp_t'(MAX_HP);
  localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_TICKS);
  localparam logic [BW-1:0] BLK_LOAD = BW'(BLINK_TICKS);

  function automatic hp_t hp_sat(input logic [4:0] v);
    if (v > {1'b0, MAX_V}) return MAX_V;
    else                   return v[3:0];
  endfunction

  health_state_t state;
  logic [IW-1:0] inv_cnt;
  logic [BW-1:0] blink_cnt;
  logic [3:0]    rise_p1;
  logic          hit_p1;
  logic [4:0]    hp_up;
  logic [4:0]    hp_net;

  rise_detect #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (got_hit),
    .rise (rise_p1)
  );

  // several ghosts rising together count as a single collision
  assign hit_p1 = |rise_p1;
  assign hp_up  = {1'b0, hp_dig} + 5'(heal);
  assign hp_net = hp_up - 5'd1;

  // stage p1 -> p2: registered FSM, counters and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ALIVE;
      hp_dig    <= START_V;
      game_over <= 1'b0;
      invuln    <= 1'b0;
      blink     <= 1'b0;
      hit_ack   <= 1'b0;
      inv_cnt   <= '0;
      blink_cnt <= '0;
    end else begin
      hit_ack <= 1'b0;
      if (restart) begin
        state     <= ALIVE;
        hp_dig    <= START_V;
        game_over <= 1'b0;
        invuln    <= 1'b0;
        blink     <= 1'b0;
        inv_cnt   <= '0;
        blink_cnt <= '0;
      end else begin
        case (state)
          ALIVE: begin
            if (hit_p1) begin
              hit_ack <= 1'b1;
              // death check uses hp after any same-cycle heal
              if (hp_net == 5'd0) begin
                state     <= DEAD;
                hp_dig    <= '0;
                game_over <= 1'b1;
              end else begin
                state     <= INVULN;
                hp_dig    <= hp_sat(hp_net);
                invuln    <= 1'b1;
                blink     <= 1'b0;
                inv_cnt   <= INV_LOAD;
                blink_cnt <= BLK_LOAD;
              end
            end else if (heal) begin
              hp_dig <= hp_sat(hp_up);
            end
          end
          INVULN: begin
            if (heal) hp_dig <= hp_sat(hp_up);
            if (tick) begin
              if (inv_cnt == IW'(1)) begin
                state     <= ALIVE;
                invuln    <= 1'b0;
                blink     <= 1'b0;
                inv_cnt   <= '0;
                blink_cnt <= '0;
              end else begin
                inv_cnt <= inv_cnt - IW'(1);
                if (blink_cnt == BW'(1)) begin
                  blink     <= ~blink;
                  blink_cnt <= BLK_LOAD;
                end else begin
                  blink_cnt <= blink_cnt - BW'(1);
                end
              end
            end
          end
          DEAD: begin
            hp_dig    <= '0;
            game_over <= 1'b1;
          end
          default: begin
            state <= ALIVE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_health_ctrl.sv
// Directed testbench for health_ctrl with hand-computed expected values.
module tb_health_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] got_hit = 4'b0000;
  logic       heal = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] hp_dig;
  logic       game_over;
  logic       invuln;
  logic       blink;
  logic       hit_ack;

  int checks = 0;
  int errors = 0;

  health_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .got_hit   (got_hit),
    .heal      (heal),
    .restart   (restart),
    .hp_dig    (hp_dig),
    .game_over (game_over),
    .invuln    (invuln),
    .blink     (blink),
    .hit_ack   (hit_ack)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] lines);
    got_hit = lines;
    tick = 1'b0; heal = 1'b0; restart = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
  endtask

  // raise a hit line and wait until the damage edge has passed, then drop it
  task automatic hit_pulse(input logic [3:0] mask);
    got_hit = mask;
    step(2);
    got_hit = 4'b0000;
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    step(n);
    tick = 1'b0;
  endtask

  task automatic test_reset;
    int acks;
    got_hit = 4'b0001;
    rst = 1'b0;
    step(1);
    checks++;
    if (hp_dig !== 4'd3 || game_over !== 1'b0 || invuln !== 1'b0 || blink !== 1'b0 || hit_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: hp=%0d go=%b inv=%b blink=%b ack=%b, want hp=3 others 0",
               hp_dig, game_over, invuln, blink, hit_ack);
    end
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (hit_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0 || hp_dig !== 4'd3) begin
      errors++;
      $display("FAIL held_line_release: acks=%0d hp=%0d, want acks=0 hp=3", acks, hp_dig);
    end
    got_hit = 4'b0000;
    step(2);
    got_hit = 4'b0001;
    step(1);
    checks++;
    if (hit_ack !== 1'b0 || hp_dig !== 4'd3) begin
      errors++;
      $display("FAIL hit_latency_early: ack=%b hp=%0d after 1 clk, want ack=0 hp=3", hit_ack, hp_dig);
    end
    step(1);
    checks++;
    if (hp_dig !== 4'd2 || hit_ack !== 1'b1 || invuln !== 1'b1) begin
      errors++;
      $display("FAIL first_hit: hp=%0d ack=%b inv=%b, want hp=2 ack=1 inv=1", hp_dig, hit_ack, invuln);
    end
    step(1);
    checks++;
    if (hit_ack !== 1'b0) begin
      errors++;
      $display("FAIL hit_ack_width: ack=%b, want 0 one clk later", hit_ack);
    end
  endtask

  task automatic test_multi_hit;
    int acks;
    logic exp_blink;
    do_reset(4'b0000);
    got_hit = 4'b0101;
    step(2);
    checks++;
    if (hp_dig !== 4'd2 || hit_ack !== 1'b1) begin
      errors++;
      $display("FAIL multi_bit_hit: hp=%0d ack=%b, want hp=2 ack=1", hp_dig, hit_ack);
    end
    acks = 0;
    got_hit = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (hit_ack === 1'b1) acks++;
    end
    got_hit = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (hit_ack === 1'b1) acks++;
    end
    got_hit = 4'b0000;
    checks++;
    if (acks != 0 || hp_dig !== 4'd2) begin
      errors++;
      $display("FAIL invuln_ignores_hits: extra_acks=%0d hp=%0d, want 0 and 2", acks, hp_dig);
    end
    exp_blink = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      if (i < 90 && (i % 8) == 0) exp_blink = ~exp_blink;
      if (i == 90) exp_blink = 1'b0;
      checks++;
      if (invuln !== (i < 90) || blink !== exp_blink) begin
        errors++;
        $display("FAIL invuln_timer tick=%0d: inv=%b blink=%b, want inv=%b blink=%b",
                 i, invuln, blink, (i < 90), exp_blink);
      end
    end
  endtask

  task automatic test_death_restart;
    do_reset(4'b0000);
    hit_pulse(4'b0001);
    checks++;
    if (hp_dig !== 4'd2) begin
      errors++;
      $display("FAIL death_hit1: hp=%0d, want 2", hp_dig);
    end
    run_ticks(90);
    hit_pulse(4'b0010);
    checks++;
    if (hp_dig !== 4'd1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL death_hit2: hp=%0d go=%b, want hp=1 go=0", hp_dig, game_over);
    end
    run_ticks(90);
    hit_pulse(4'b0100);
    checks++;
    if (hp_dig !== 4'd0 || game_over !== 1'b1 || hit_ack !== 1'b1 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL death_hit3: hp=%0d go=%b ack=%b inv=%b, want hp=0 go=1 ack=1 inv=0",
               hp_dig, game_over, hit_ack, invuln);
    end
    heal = 1'b1;
    step(1);
    heal = 1'b0;
    hit_pulse(4'b1000);
    checks++;
    if (hp_dig !== 4'd0 || game_over !== 1'b1 || hit_ack !== 1'b0) begin
      errors++;
      $display("FAIL dead_ignores: hp=%0d go=%b ack=%b, want hp=0 go=1 ack=0", hp_dig, game_over, hit_ack);
    end
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    checks++;
    if (hp_dig !== 4'd3 || game_over !== 1'b0 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL restart: hp=%0d go=%b inv=%b, want hp=3 go=0 inv=0", hp_dig, game_over, invuln);
    end
    step(2);
    hit_pulse(4'b0001);
    checks++;
    if (hp_dig !== 4'd2 || invuln !== 1'b1) begin
      errors++;
      $display("FAIL restart_alive: hp=%0d inv=%b, want hp=2 inv=1", hp_dig, invuln);
    end
  endtask

  task automatic test_heal;
    do_reset(4'b0000);
    heal = 1'b1;
    step(5);
    checks++;
    if (hp_dig !== 4'd8) begin
      errors++;
      $display("FAIL heal_count: hp=%0d, want 8", hp_dig);
    end
    step(2);
    heal = 1'b0;
    checks++;
    if (hp_dig !== 4'd9) begin
      errors++;
      $display("FAIL heal_saturate: hp=%0d, want 9", hp_dig);
    end
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    hit_pulse(4'b0001);
    run_ticks(90);
    hit_pulse(4'b0001);
    run_ticks(90);
    checks++;
    if (hp_dig !== 4'd1 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL heal_setup: hp=%0d inv=%b, want hp=1 inv=0", hp_dig, invuln);
    end
    got_hit = 4'b0010;
    step(1);
    heal = 1'b1;
    step(1);
    heal = 1'b0;
    got_hit = 4'b0000;
    checks++;
    if (hp_dig !== 4'd1 || invuln !== 1'b1 || game_over !== 1'b0 || hit_ack !== 1'b1) begin
      errors++;
      $display("FAIL heal_with_hit: hp=%0d inv=%b go=%b ack=%b, want hp=1 inv=1 go=0 ack=1",
               hp_dig, invuln, game_over, hit_ack);
    end
  endtask

  task automatic test_async_reset;
    do_reset(4'b0000);
    hit_pulse(4'b0001);
    run_ticks(50);
    checks++;
    if (dut.inv_cnt !== 7'd40 || invuln !== 1'b1 || hp_dig !== 4'd2) begin
      errors++;
      $display("FAIL mid_invuln: inv_cnt=%0d inv=%b hp=%0d, want 40 1 2", dut.inv_cnt, invuln, hp_dig);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (hp_dig !== 4'd3 || invuln !== 1'b0 || blink !== 1'b0 || game_over !== 1'b0 || hit_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: hp=%0d inv=%b blink=%b go=%b ack=%b, want hp=3 others 0",
               hp_dig, invuln, blink, game_over, hit_ack);
    end
    step(1);
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_hit_tick;
    do_reset(4'b0000);
    got_hit = 4'b0001;
    step(1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    got_hit = 4'b0000;
    checks++;
    if (dut.inv_cnt !== 7'd90 || invuln !== 1'b1) begin
      errors++;
      $display("FAIL hit_with_tick: inv_cnt=%0d inv=%b, want 90 1", dut.inv_cnt, invuln);
    end
    run_ticks(1);
    checks++;
    if (dut.inv_cnt !== 7'd89) begin
      errors++;
      $display("FAIL first_decrement: inv_cnt=%0d, want 89", dut.inv_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_multi_hit();
    test_death_restart();
    test_heal();
    test_async_reset();
    test_hit_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
